// File: rtl/reg_writeback.sv
// ============================================================================
// Module   : reg_writeback
// Purpose  : Writeback arbiter (ALU vs. queued load returns) with per-register
//            load-pending scoreboard. Optional macro WB_BYPASS_EN adds bypass.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
`ifndef LOG_REG_NUM
`define LOG_REG_NUM 5
`endif

module reg_writeback #(
    parameter int LQ_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_valid,
    input  logic [`LOG_REG_NUM-1:0] alu_rd,
    input  logic [`DATA_SIZE-1:0]   alu_data,
    output logic                    alu_ready,
    input  logic                    ld_issue,
    input  logic [`LOG_REG_NUM-1:0] ld_rd,
    input  logic                    lsu_valid,
    input  logic [`LOG_REG_NUM-1:0] lsu_rd,
    input  logic [`DATA_SIZE-1:0]   lsu_data,
    output logic                    lsu_ready,
    input  logic [`LOG_REG_NUM-1:0] chk_rs1,
    input  logic [`LOG_REG_NUM-1:0] chk_rs2,
    output logic                    pend_rs1,
    output logic                    pend_rs2,
`ifdef WB_BYPASS_EN
    output logic                    byp_hit1,
    output logic                    byp_hit2,
    output logic [`DATA_SIZE-1:0]   byp_data,
`endif
    output logic                    regwrite,
    output logic [`LOG_REG_NUM-1:0] write_rd,
    output logic [`DATA_SIZE-1:0]   write_data
);

    localparam int c_aw   = $clog2(LQ_DEPTH);
    localparam int c_nreg = 1 << `LOG_REG_NUM;

    logic [c_aw:0]             r_wr_ptr;
    logic [c_aw:0]             r_rd_ptr;
    logic [`LOG_REG_NUM-1:0]   r_q_rd   [LQ_DEPTH];
    logic [`DATA_SIZE-1:0]     r_q_data [LQ_DEPTH];
    logic [c_nreg-1:0]         r_pending;
    logic [c_nreg-1:0]         w_pend_next;

    logic                      w_empty;
    logic                      w_full;
    logic                      w_alu_take;
    logic                      w_push;
    logic                      w_pop;
    logic [`LOG_REG_NUM-1:0]   w_head_rd;
    logic [`DATA_SIZE-1:0]     w_head_data;

    // Extra pointer MSB separates full (MSBs differ) from empty (all equal).
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);

    assign alu_ready = !rst && !w_full;
    assign lsu_ready = !rst && !w_full;

    assign w_alu_take  = !rst && alu_valid && !w_full;
    assign w_push      = !rst && lsu_valid && !w_full;
    assign w_pop       = !rst && !w_alu_take && !w_empty;
    assign w_head_rd   = r_q_rd[r_rd_ptr[c_aw-1:0]];
    assign w_head_data = r_q_data[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_rd[r_wr_ptr[c_aw-1:0]]   <= lsu_rd;
            r_q_data[r_wr_ptr[c_aw-1:0]] <= lsu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Clear first, then set, so a same-cycle issue to the popped register wins.
    always_comb begin
        w_pend_next = r_pending;
        if (w_pop)
            w_pend_next[w_head_rd] = 1'b0;
        if (ld_issue && (ld_rd != '0))
            w_pend_next[ld_rd] = 1'b1;
        w_pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) r_pending <= '0;
        else     r_pending <= w_pend_next;
    end

    assign pend_rs1 = r_pending[chk_rs1];
    assign pend_rs2 = r_pending[chk_rs2];

    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite   <= 1'b0;
            write_rd   <= '0;
            write_data <= '0;
        end else if (w_alu_take) begin
            regwrite   <= (alu_rd != '0);
            write_rd   <= alu_rd;
            write_data <= alu_data;
        end else if (w_pop) begin
            regwrite   <= (w_head_rd != '0);
            write_rd   <= w_head_rd;
            write_data <= w_head_data;
        end else begin
            regwrite   <= 1'b0;
        end
    end

`ifdef WB_BYPASS_EN
    assign byp_hit1 = regwrite && (chk_rs1 != '0) && (write_rd == chk_rs1);
    assign byp_hit2 = regwrite && (chk_rs2 != '0) && (write_rd == chk_rs2);
    assign byp_data = write_data;
`endif

endmodule

`default_nettype wire

// File: tb/tb_reg_writeback.sv
// ============================================================================
// Module   : tb_reg_writeback
// Purpose  : Self-checking bench for reg_writeback (tables, corner sequences,
//            random traffic against a queue-based reference model).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
`ifndef LOG_REG_NUM
`define LOG_REG_NUM 5
`endif

module tb_reg_writeback;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready, ld_issue, lsu_valid, lsu_ready;
    logic [4:0]  alu_rd, ld_rd, lsu_rd, chk_rs1, chk_rs2, write_rd;
    logic [31:0] alu_data, lsu_data, write_data;
    logic        pend_rs1, pend_rs2, regwrite;
`ifdef WB_BYPASS_EN
    logic        byp_hit1, byp_hit2;
    logic [31:0] byp_data;
`endif

    always #5 clk = ~clk;

    reg_writeback #(.LQ_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .ld_issue   (ld_issue),
        .ld_rd      (ld_rd),
        .lsu_valid  (lsu_valid),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .lsu_ready  (lsu_ready),
        .chk_rs1    (chk_rs1),
        .chk_rs2    (chk_rs2),
        .pend_rs1   (pend_rs1),
        .pend_rs2   (pend_rs2),
`ifdef WB_BYPASS_EN
        .byp_hit1   (byp_hit1),
        .byp_hit2   (byp_hit2),
        .byp_data   (byp_data),
`endif
        .regwrite   (regwrite),
        .write_rd   (write_rd),
        .write_data (write_data)
    );

    typedef struct {
        logic        alu_v;
        logic [4:0]  alu_rd;
        logic [31:0] alu_d;
        logic        ld_i;
        logic [4:0]  ld_rd;
        logic        lsu_v;
        logic [4:0]  lsu_rd;
        logic [31:0] lsu_d;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } in_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
    } vec_t;

    ent_t        mq[$];
    logic [31:0] mpend;
    int          checks = 0;
    int          errors = 0;
    vec_t        tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t idle();
        in_t v;
        v.alu_v = 1'b0; v.alu_rd = '0; v.alu_d = '0;
        v.ld_i  = 1'b0; v.ld_rd  = '0;
        v.lsu_v = 1'b0; v.lsu_rd = '0; v.lsu_d = '0;
        v.rs1   = '0;   v.rs2    = '0;
        return v;
    endfunction

    task automatic drive(input in_t v);
        alu_valid = v.alu_v; alu_rd = v.alu_rd; alu_data = v.alu_d;
        ld_issue  = v.ld_i;  ld_rd  = v.ld_rd;
        lsu_valid = v.lsu_v; lsu_rd = v.lsu_rd; lsu_data = v.lsu_d;
        chk_rs1   = v.rs1;   chk_rs2 = v.rs2;
    endtask

    // One clock of traffic: check combinational outputs, advance the model,
    // then check the registered writeback after the edge.
    task automatic apply(input in_t v);
        logic        full, alu_take, pop, ewe;
        logic [4:0]  erd;
        logic [31:0] edata;
        ent_t        h;
        @(negedge clk);
        drive(v);
        #1;
        full = (mq.size() == DEPTH);
        chk("alu_ready", alu_ready, !full);
        chk("lsu_ready", lsu_ready, !full);
        chk("pend_rs1", pend_rs1, mpend[v.rs1]);
        chk("pend_rs2", pend_rs2, mpend[v.rs2]);
        alu_take = v.alu_v && !full;
        pop      = !alu_take && (mq.size() != 0);
        ewe = 1'b0; erd = '0; edata = '0;
        if (alu_take) begin
            ewe = (v.alu_rd != 0); erd = v.alu_rd; edata = v.alu_d;
        end else if (pop) begin
            h = mq.pop_front();
            ewe = (h.rd != 0); erd = h.rd; edata = h.data;
            mpend[h.rd] = 1'b0;
        end
        if (v.ld_i && v.ld_rd != 0) mpend[v.ld_rd] = 1'b1;
        if (v.lsu_v && !full) mq.push_back(ent_t'{v.lsu_rd, v.lsu_d});
        @(posedge clk);
        #1;
        chk("regwrite", regwrite, ewe);
        if (ewe) begin
            chk("write_rd", write_rd, erd);
            chk("write_data", write_data, edata);
        end
`ifdef WB_BYPASS_EN
        chk("byp_hit1", byp_hit1, ewe && erd == v.rs1 && v.rs1 != 0);
        chk("byp_hit2", byp_hit2, ewe && erd == v.rs2 && v.rs2 != 0);
        if (ewe) chk("byp_data", byp_data, edata);
`endif
    endtask

    // Reset with random garbage on the inputs, which must be ignored.
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst       = 1'b1;
            alu_valid = 1'($urandom); alu_rd = 5'($urandom); alu_data = $urandom;
            ld_issue  = 1'($urandom); ld_rd  = 5'($urandom);
            lsu_valid = 1'($urandom); lsu_rd = 5'($urandom); lsu_data = $urandom;
            #1;
            chk("rst_alu_ready", alu_ready, 0);
            chk("rst_lsu_ready", lsu_ready, 0);
        end
        @(posedge clk);
        #1;
        mq.delete();
        mpend = '0;
        chk("rst_regwrite", regwrite, 0);
        chk("rst_write_rd", write_rd, 0);
        chk("rst_write_data", write_data, 0);
        rst = 1'b0;
        drive(idle());
    endtask

    initial begin
        in_t        v;
        logic [31:0] got[$];

        rst = 1'b1;
        drive(idle());
        mpend = '0;
        do_reset(2);

        // Single ALU results from an empty queue
        tbl[0] = '{5'd5,  32'h0000_1234, 1'b1};
        tbl[1] = '{5'd0,  32'hFFFF_FFFF, 1'b0};
        tbl[2] = '{5'd31, 32'hDEAD_BEEF, 1'b1};
        tbl[3] = '{5'd1,  32'h0000_0000, 1'b1};
        for (int i = 0; i < 4; i++) begin
            v = idle(); v.alu_v = 1'b1; v.alu_rd = tbl[i].rd; v.alu_d = tbl[i].data;
            apply(v);
            chk("tbl_we", regwrite, tbl[i].we);
            if (tbl[i].we) begin
                chk("tbl_rd", write_rd, tbl[i].rd);
                chk("tbl_data", write_data, tbl[i].data);
            end
        end

        // Load pending set, return, writeback, then pending clear
        v = idle(); v.ld_i = 1'b1; v.ld_rd = 5'd7; apply(v);
        v = idle(); v.rs1 = 5'd7; apply(v);
        chk("pend7_set", pend_rs1, 1);
        v = idle(); v.lsu_v = 1'b1; v.lsu_rd = 5'd7; v.lsu_d = 32'h0000_CAFE; v.rs1 = 5'd7; apply(v);
        v = idle(); v.rs1 = 5'd7; apply(v);
        chk("ld_we", regwrite, 1);
        chk("ld_rd", write_rd, 7);
        chk("ld_data", write_data, 32'h0000_CAFE);
        chk("pend7_clr", pend_rs1, 0);

        // Fill the queue under continuous ALU traffic, then drain in order
        for (int k = 0; k < 4; k++) begin
            v = idle();
            v.alu_v = 1'b1; v.alu_rd = 5'(10 + k); v.alu_d = 32'hB000_0000 + k;
            v.lsu_v = 1'b1; v.lsu_rd = 5'(20 + k); v.lsu_d = 32'hA000_0000 + k;
            apply(v);
        end
        chk("full_lsu_ready", lsu_ready, 0);
        chk("full_alu_ready", alu_ready, 0);
        for (int k = 0; k < 12; k++) begin
            v = idle();
            v.alu_v = (k < 3); v.alu_rd = 5'd12; v.alu_d = 32'hC000_0000 + k;
            apply(v);
            if (regwrite && write_rd >= 5'd20 && write_rd <= 5'd23) got.push_back(write_data);
        end
        chk("drain_count", got.size(), 4);
        for (int k = 0; k < 4 && k < got.size(); k++)
            chk("drain_order", got[k], 32'hA000_0000 + k);

        // Same-cycle set and clear of register 3 leaves it pending
        v = idle(); v.ld_i = 1'b1; v.ld_rd = 5'd3; apply(v);
        v = idle(); v.lsu_v = 1'b1; v.lsu_rd = 5'd3; v.lsu_d = 32'h0000_0033; apply(v);
        v = idle(); v.ld_i = 1'b1; v.ld_rd = 5'd3; v.rs1 = 5'd3; apply(v);
        chk("wb3_we", regwrite, 1);
        chk("wb3_rd", write_rd, 3);
        chk("pend3_kept", pend_rs1, 1);

        // Reset with three entries queued discards them
        for (int k = 0; k < 3; k++) begin
            v = idle();
            v.alu_v = 1'b1; v.alu_rd = 5'd1; v.alu_d = k;
            v.lsu_v = 1'b1; v.lsu_rd = 5'(8 + k); v.lsu_d = 32'hD000_0000 + k;
            v.ld_i  = 1'b1; v.ld_rd  = 5'(8 + k);
            apply(v);
        end
        do_reset(1);
        for (int k = 0; k < 5; k++) begin
            apply(idle());
            chk("post_rst_we", regwrite, 0);
        end
        chk("post_rst_lsu_ready", lsu_ready, 1);
        for (int r = 0; r < 32; r++) begin
            @(negedge clk);
            chk_rs1 = 5'(r); chk_rs2 = 5'(31 - r);
            #1;
            chk("post_rst_pend1", pend_rs1, 0);
            chk("post_rst_pend2", pend_rs2, 0);
        end

        // Random traffic against the model, with one mid-stream reset
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset(1);
            v.alu_v  = ($urandom_range(0, 99) < 45);
            v.alu_rd = 5'($urandom); v.alu_d = $urandom;
            v.ld_i   = ($urandom_range(0, 99) < 30);
            v.ld_rd  = 5'($urandom);
            v.lsu_v  = ($urandom_range(0, 99) < 40);
            v.lsu_rd = 5'($urandom); v.lsu_d = $urandom;
            v.rs1    = 5'($urandom); v.rs2 = 5'($urandom);
            apply(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
